// File: rtl/fifo_drain_arbiter_pkg.sv
// Shared defaults and FSM encoding for the queue-drain arbiter and the FIFOs feeding it.
package fifo_drain_arbiter_pkg;

  localparam int NQ_DEF    = 4;
  localparam int MSBD_DEF  = 3;
  localparam int BURST_DEF = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SERVE = 1'b1
  } state_t;

  // Index width that stays legal (>= 1 bit) even for a single queue or BURST of 1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_drain_arbiter_if.sv
// Bundle between the upstream FIFOs / downstream consumer and the drain arbiter.
interface fifo_drain_arbiter_if
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int NQ   = NQ_DEF,
  parameter int MSBD = MSBD_DEF
) ();

  logic [NQ-1:0]          qEmpty;
  logic [NQ-1:0]          qPush;
  logic [NQ*(MSBD+1)-1:0] qData;
  logic [NQ-1:0]          qPop;
  logic [MSBD:0]          outData;
  logic                   outValid;
  logic                   outReady;
  logic [NQ-1:0]          grant;

  modport master (
    input  qEmpty, qPush, qData, outReady,
    output qPop, outData, outValid, grant
  );

  modport slave (
    output qEmpty, qPush, qData, outReady,
    input  qPop, outData, outValid, grant
  );

endinterface

// File: rtl/fifo_drain_arbiter_rr_pick.sv
// Rotating-priority picker: first set request at or after start, wrapping modulo N.
// Purely combinational; any is simply the OR of all requests.
module rr_pick
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int N  = NQ_DEF,
  parameter int IW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  logic [IW:0]    sum;

  assign req2 = {req, req};
  assign rot  = N'(req2 >> start);
  assign any  = |req;

  // Scan from the far end so the lowest rotated offset is the one that sticks.
  always_comb begin
    sum = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, start} + (IW+1)'(i);
      end
    end
    if (sum >= (IW+1)'(N)) begin
      sum = sum - (IW+1)'(N);
    end
    idx = sum[IW-1:0];
  end

endmodule

// File: rtl/fifo_drain_arbiter.sv
// Drains NQ upstream FIFOs round-robin into one registered word, up to BURST service events per grant.
// One word per clock while outReady holds; one IDLE bubble per grant change; a stalled output freezes pops and cnt.
module fifo_drain_arbiter
  import fifo_drain_arbiter_pkg::*;
#(
  parameter int NQ    = NQ_DEF,
  parameter int MSBD  = MSBD_DEF,
  parameter int BURST = BURST_DEF
) (
  input logic clock,
  input logic reset,
  fifo_drain_arbiter_if.master bus
);

  localparam int W  = MSBD + 1;
  localparam int IW = idx_width(NQ);
  localparam int CW = idx_width(BURST);

  state_t        state;
  logic [IW-1:0] cur;
  logic [IW-1:0] ptr;
  logic [IW-1:0] cur_next;
  logic [IW-1:0] pick_idx;
  logic [CW-1:0] cnt;
  logic [NQ-1:0] grant_q;
  logic [MSBD:0] out_data_q;
  logic          out_valid_q;
  logic          pick_any;
  logic          can_load;
  logic          serve_evt;
  logic          pop_now;
  logic          last_evt;
  logic [NQ-1:0] req_vec;
  logic [MSBD:0] words [NQ];

  for (genvar k = 0; k < NQ; k++) begin : g_unpack
    assign words[k] = bus.qData[k*W +: W];
  end

  assign req_vec = ~bus.qEmpty;

  rr_pick #(.N(NQ), .IW(IW)) u_pick (
    .req   (req_vec),
    .start (ptr),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign can_load  = ~out_valid_q | bus.outReady;
  assign serve_evt = (state == ST_SERVE) & can_load & ~bus.qEmpty[cur];
  // A push on the served queue wins upstream, so that event is spent without popping.
  assign pop_now   = serve_evt & ~bus.qPush[cur] & ~reset;
  assign last_evt  = (cnt == CW'(BURST - 1));
  assign cur_next  = (cur == IW'(NQ - 1)) ? '0 : cur + 1'b1;

  assign bus.qPop     = pop_now ? (NQ'(1) << cur) : '0;
  assign bus.grant    = grant_q;
  assign bus.outData  = out_data_q;
  assign bus.outValid = out_valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cur         <= '0;
      ptr         <= '0;
      cnt         <= '0;
      grant_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (pop_now) begin
        out_data_q  <= words[cur];
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.outReady) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state   <= ST_SERVE;
            cur     <= pick_idx;
            cnt     <= '0;
            grant_q <= NQ'(1) << pick_idx;
          end
        end
        ST_SERVE: begin
          if (bus.qEmpty[cur]) begin
            state   <= ST_IDLE;
            ptr     <= cur_next;
            grant_q <= '0;
          end else if (serve_evt) begin
            if (last_evt) begin
              state   <= ST_IDLE;
              ptr     <= cur_next;
              cnt     <= '0;
              grant_q <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_drain_arbiter.sv
// Directed and random checks of the drain arbiter against per-queue FIFO and delivery-order models.
module tb_fifo_drain_arbiter;
  import fifo_drain_arbiter_pkg::*;

  localparam int NQ    = 4;
  localparam int MSBD  = 7;
  localparam int BURST = 4;
  localparam int W     = MSBD + 1;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fifo_drain_arbiter_if #(.NQ(NQ), .MSBD(MSBD)) bus ();

  fifo_drain_arbiter #(.NQ(NQ), .MSBD(MSBD), .BURST(BURST)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Upstream FIFO contents and the words still owed to the consumer, per queue.
  logic [MSBD:0] fifo [NQ][$];
  logic [MSBD:0] expq [NQ][$];
  int            seq  [NQ] = '{default: 0};
  int            pop_log [$];

  logic [NQ-1:0] push_sel = '0;
  logic          ready    = 1'b0;
  logic [NQ-1:0] grant_s  = '0;
  logic [NQ-1:0] pop_s    = '0;
  logic [NQ-1:0] empty_s  = '0;
  logic          vld_s    = 1'b0;
  logic [MSBD:0] dat_s    = '0;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Words carry their queue id in the top two bits so deliveries can be routed to a scoreboard.
  task automatic new_word(input int k, output logic [MSBD:0] w);
    w = {k[1:0], seq[k][5:0]};
    seq[k]++;
  endtask

  task automatic preload(input int k, input int n);
    logic [MSBD:0] w;
    for (int i = 0; i < n; i++) begin
      new_word(k, w);
      fifo[k].push_back(w);
      expq[k].push_back(w);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int k = 0; k < NQ; k++) s += fifo[k].size();
    return s;
  endfunction

  function automatic int owed();
    int s = 0;
    for (int k = 0; k < NQ; k++) s += expq[k].size();
    return s;
  endfunction

  // One clock: drive at negedge, sample just after, let the edge happen, then update the models.
  task automatic tick();
    logic [NQ*W-1:0] d;
    logic [MSBD:0]   w;
    int              q;
    d = '0;
    for (int k = 0; k < NQ; k++) begin
      empty_s[k] = (fifo[k].size() == 0);
      if (fifo[k].size() != 0) d[k*W +: W] = fifo[k][0];
    end
    bus.qEmpty   = empty_s;
    bus.qData    = d;
    bus.qPush    = push_sel;
    bus.outReady = ready;
    #1;
    pop_s   = bus.qPop;
    grant_s = bus.grant;
    vld_s   = bus.outValid;
    dat_s   = bus.outData;
    chk("pop_onehot", 32'($countones(pop_s) <= 1), 1);
    chk("pop_outside_grant", 32'(pop_s & ~grant_s), 0);
    chk("pop_illegal", 32'(pop_s & (empty_s | push_sel)), 0);
    if (reset) chk("pop_in_reset", 32'(pop_s), 0);
    if (!reset && vld_s && ready) begin
      q = int'(dat_s[MSBD -: 2]);
      chk("deliver_expected", 32'(expq[q].size() != 0), 1);
      if (expq[q].size() != 0) chk("deliver_order", 32'(dat_s), 32'(expq[q].pop_front()));
    end
    @(posedge clock);
    if (reset && vld_s) begin
      q = int'(dat_s[MSBD -: 2]);
      if (expq[q].size() != 0) void'(expq[q].pop_front());
    end
    for (int k = 0; k < NQ; k++) begin
      if (pop_s[k] && fifo[k].size() != 0) begin
        void'(fifo[k].pop_front());
        pop_log.push_back(k);
      end
      if (push_sel[k]) begin
        new_word(k, w);
        fifo[k].push_back(w);
        expq[k].push_back(w);
      end
    end
    @(negedge clock);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    push_sel = '0;
    ready    = 1'b1;
    while ((pending() != 0 || vld_s) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < budget), 1);
    repeat (3) tick();
    chk({tag, "_owed"}, 32'(owed()), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NQ-1:0] exp_g [11];
    logic [NQ-1:0] exp_p [11];
    int            exp_log [$];
    int            run_q [6];
    int            run_n [6];
    logic [MSBD:0] held;
    int            n;
    int            p;
    int            g_cnt;

    bus.qEmpty   = '1;
    bus.qPush    = '0;
    bus.qData    = '0;
    bus.outReady = 1'b0;
    reset        = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);

    // Reset state, with queues 1 and 3 already loaded.
    preload(1, 3);
    preload(3, 3);
    ready = 1'b1;
    tick();
    chk("reset_grant", 32'(grant_s), 0);
    chk("reset_valid", 32'(vld_s), 0);
    chk("reset_data", 32'(dat_s), 0);
    chk("reset_pop", 32'(pop_s), 0);
    reset = 1'b0;

    // Two short queues: three pops each, a single IDLE cycle between grants.
    exp_g = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h2, 4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h0};
    exp_p = '{4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0};
    for (int i = 0; i < 11; i++) begin
      tick();
      chk("t30_grant", 32'(grant_s), 32'(exp_g[i]));
      chk("t30_pop", 32'(pop_s), 32'(exp_p[i]));
    end
    drain("t30_drain", 100);

    // Two deep queues alternate in bursts of BURST until both run dry.
    pop_log.delete();
    preload(0, 10);
    preload(2, 10);
    drain("t31_drain", 200);
    run_q = '{0, 2, 0, 2, 0, 2};
    run_n = '{4, 4, 4, 4, 2, 2};
    for (int r = 0; r < 6; r++)
      for (int j = 0; j < run_n[r]; j++) exp_log.push_back(run_q[r]);
    chk("t31_pop_count", 32'(pop_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < pop_log.size(); i++)
      chk("t31_pop_queue", 32'(pop_log[i]), 32'(exp_log[i]));

    // Output stall right after the first load freezes data, pops and the burst count.
    preload(1, 6);
    ready = 1'b0;
    n = 0;
    while (!vld_s && n < 10) begin
      tick();
      n++;
    end
    chk("t32_load", 32'(vld_s), 1);
    held = dat_s;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t32_hold_valid", 32'(vld_s), 1);
      chk("t32_hold_data", 32'(dat_s), 32'(held));
      chk("t32_no_pop", 32'(pop_s), 0);
      chk("t32_grant", 32'(grant_s), 32'h2);
    end
    ready = 1'b1;
    p = 0;
    n = 0;
    do begin
      tick();
      if (grant_s != '0) p += int'(pop_s != '0);
      n++;
    end while (grant_s != '0 && n < 20);
    chk("t32_burst_rest", 32'(p), 32'(BURST - 1));
    drain("t32_drain", 200);

    // Continuous push on the served queue: no pops, grant moves on after BURST cycles.
    preload(0, 2);
    preload(1, 2);
    push_sel = 4'b0001;
    ready    = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (grant_s == '0 && n < 5);
    chk("t33_first_grant", 32'(grant_s), 32'h1);
    g_cnt = 0;
    p     = 0;
    while (grant_s == 4'b0001 && g_cnt < 20) begin
      g_cnt++;
      p += int'(pop_s != '0);
      tick();
    end
    chk("t33_grant_cycles", 32'(g_cnt), 32'(BURST));
    chk("t33_pops", 32'(p), 0);
    chk("t33_idle", 32'(grant_s), 0);
    tick();
    chk("t33_next_grant", 32'(grant_s), 32'h2);
    drain("t33_drain", 300);

    // Reset while a word is held mid-burst on queue 2.
    preload(1, 6);
    preload(2, 3);
    ready = 1'b1;
    n = 0;
    while (!(grant_s == 4'b0100 && vld_s) && n < 60) begin
      tick();
      n++;
    end
    chk("t34_setup", 32'(n < 60), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("t34_valid", 32'(vld_s), 0);
    chk("t34_grant", 32'(grant_s), 0);
    chk("t34_pop", 32'(pop_s), 0);
    tick();
    chk("t34_ptr_grant", 32'(grant_s), 32'h2);
    drain("t34_drain", 200);

    // Random pushes and consumer stalls, then drain everything.
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < NQ; k++) push_sel[k] = ($urandom_range(99) < 15);
      ready = ($urandom_range(99) < 70);
      tick();
    end
    drain("t35_drain", 5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_drain_arbiter.md
FIFO_DRAIN_ARBITER -- requirements
Module: fifo_drain_arbiter

Interface
- REQ-001 Parameter NQ, default 4: number of upstream queues.
- REQ-002 Parameter MSBD, default 3: data MSB; word width is MSBD+1.
- REQ-003 Parameter BURST, default 4: maximum service events per grant.
- REQ-004 Port clock, input, 1: single clock; all state updates on posedge.
- REQ-005 Port reset, input, 1: synchronous, active-high reset.
- REQ-006 Port qEmpty, input, NQ: per-queue empty flag from upstream FIFOs.
- REQ-007 Port qPush, input, NQ: per-queue push line as seen by that FIFO; push has priority over pop upstream.
- REQ-008 Port qData, input, NQ*(MSBD+1): flattened head words; queue k occupies bits [k*(MSBD+1) +: MSBD+1].
- REQ-009 Port qPop, output, NQ: per-queue pop strobe, at most one bit set.
- REQ-010 Port outData, output, MSBD+1: registered output word.
- REQ-011 Port outValid, output, 1: outData holds an undelivered word.
- REQ-012 Port outReady, input, 1: consumer accepts outData when outValid & outReady at an edge.
- REQ-013 Port grant, output, NQ: one-hot current queue in SERVE; all zero in IDLE.

Function
- REQ-014 The block SHALL use a two-state FSM: IDLE and SERVE; registers cur (queue index), ptr (round-robin start), cnt (0..BURST-1).
- REQ-015 In IDLE, if any qEmpty bit is 0 at an edge, the block SHALL set cur to the first non-empty index at or after ptr (mod NQ), clear cnt, and enter SERVE; otherwise it SHALL stay in IDLE.
- REQ-016 canLoad = ~outValid | outReady; in SERVE, qPop[cur] SHALL be canLoad & ~qEmpty[cur] & ~qPush[cur], combinationally; qPop SHALL be all zero in IDLE.
- REQ-017 On an edge with qPop[cur]=1, the block SHALL load outData from the qData slice of cur, set outValid=1, and increment cnt.
- REQ-018 On an edge in SERVE with canLoad & ~qEmpty[cur] & qPush[cur] (push conflict), the block SHALL not pop but SHALL still increment cnt.
- REQ-019 When the increment of REQ-017/REQ-018 occurs with cnt==BURST-1, the block SHALL enter IDLE and set ptr=(cur+1) mod NQ.
- REQ-020 In SERVE, if qEmpty[cur]=1 at an edge, the block SHALL enter IDLE with ptr=(cur+1) mod NQ, and no pop SHALL occur.
- REQ-021 On an edge with outValid & outReady and no pop, outValid SHALL clear; outData holds its value.
- REQ-022 With outValid & ~outReady, outData and outValid SHALL hold and no pop SHALL be issued; cnt SHALL not change.
- REQ-023 With outReady held 1, pops from the served queue SHALL occur on consecutive cycles (one word per clock); IDLE costs exactly one bubble cycle per grant change.
- REQ-024 With outReady held 1, every non-empty queue SHALL be granted within (NQ-1)*(BURST+1)+1 cycles.
- REQ-025 Data order per queue SHALL be preserved; no word SHALL be duplicated or dropped outside reset.

Reset
- REQ-026 On reset: state=IDLE, ptr=0, cur=0, cnt=0, outValid=0, outData=0, grant=0, qPop=0.
- REQ-027 Reset asserted mid-burst SHALL discard any word held in outData; qPop SHALL be 0 in the reset cycle and the following cycle.

Structure
- REQ-028 Defaults for NQ, MSBD and BURST and the FSM state encodings SHALL reside in a shared package used by the FIFOs and this block.
- REQ-029 The rotating priority selection of REQ-015 SHALL be one sub-module, rr_pick (inputs: request vector, start index; outputs: index, any).

Verification
- REQ-030 After reset, queues 1 and 3 non-empty (3 words each), outReady=1 -> grant=0010 for 3 pops, one IDLE cycle, grant=1000 for 3 pops, then IDLE.
- REQ-031 Queue 0 holds 10 words, queue 2 holds 10 words, BURST=4 -> pop pattern 4 from q0, 4 from q2, 4 from q0, 4 from q2, 2 from q0, 2 from q2.
- REQ-032 outReady=0 for 5 cycles after the first load -> outData stable, outValid=1, qPop=0 throughout, cnt unchanged; resumes with no loss.
- REQ-033 qPush[cur]=1 continuously on a non-empty queue -> no pops, grant leaves after BURST cycles to the next non-empty queue.
- REQ-034 Reset asserted with outValid=1 mid-burst -> next cycle outValid=0, grant=0, ptr=0.
- REQ-035 Random stimulus with a reference model per queue -> words delivered in per-queue order, never duplicated, and qPop at most one-hot, at every cycle.
